// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores onto the shared data
// memory. Checks alignment, builds byte enables and lane-replicated store
// data, waits out the memory busywait handshake (bounded by a timeout) and
// returns sign/zero-extended load data. BUSYWAIT stalls the pipeline while
// an access is outstanding.
module dmem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MEM_READ,
  input  logic              MEM_WRITE,
  input  logic [2:0]        FUNCT3,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [31:0]       WRITE_DATA,
  output logic [31:0]       READ_DATA,
  output logic              BUSYWAIT,
  output logic              MISALIGNED,
  output logic              MEM_FAULT,
  output logic              DMEM_READ,
  output logic              DMEM_WRITE,
  output logic [ADDR_W-1:0] DMEM_ADDR,
  output logic [31:0]       DMEM_WDATA,
  output logic [3:0]        DMEM_BYTEEN,
  input  logic [31:0]       DMEM_RDATA,
  input  logic              DMEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              is_write_q, is_write_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              dmem_read_q, dmem_read_d;
  logic              dmem_write_q, dmem_write_d;
  logic              misaligned_q, misaligned_d;
  logic              mem_fault_q, mem_fault_d;

  logic              req_any;
  logic              illegal;
  logic              misal;

  // Extract the addressed byte/halfword from a memory word and extend it.
  function automatic logic [31:0] load_refine(input logic [2:0]  f,
                                              input logic [1:0]  off,
                                              input logic [31:0] w);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replicate store data across every lane it could land in.
  function automatic logic [31:0] store_wdata(input logic [2:0]  f,
                                              input logic [31:0] d);
    case (f[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Byte-lane enables for a store of the given size at the given offset.
  function automatic logic [3:0] store_be(input logic [2:0] f,
                                          input logic [1:0] off);
    case (f[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Classify the incoming request: illegal encodings outrank misalignment.
  always_comb begin
    req_any = MEM_READ | MEM_WRITE;
    illegal = (MEM_READ & MEM_WRITE)
            | (FUNCT3 == 3'b011) | (FUNCT3 == 3'b110) | (FUNCT3 == 3'b111)
            | (MEM_WRITE & FUNCT3[2]);
    case (FUNCT3)
      3'b001, 3'b101: misal = ADDRESS[0];
      3'b010:         misal = |ADDRESS[1:0];
      default:        misal = 1'b0;
    endcase
  end

  // Next-state, capture and stall logic of the access sequencer.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    is_write_d   = is_write_q;
    cnt_d        = cnt_q;
    read_data_d  = read_data_q;
    dmem_read_d  = dmem_read_q;
    dmem_write_d = dmem_write_q;
    misaligned_d = 1'b0;
    mem_fault_d  = 1'b0;
    BUSYWAIT     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (illegal) begin
            mem_fault_d = 1'b1;
          end else if (misal) begin
            misaligned_d = 1'b1;
          end else begin
            BUSYWAIT     = 1'b1;
            addr_d       = ADDRESS;
            funct3_d     = FUNCT3;
            wdata_d      = WRITE_DATA;
            is_write_d   = MEM_WRITE;
            cnt_d        = '0;
            dmem_read_d  = MEM_READ;
            dmem_write_d = MEM_WRITE;
            state_d      = ACCESS;
          end
        end
      end
      ACCESS: begin
        BUSYWAIT = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (!DMEM_BUSYWAIT) begin
          if (!is_write_q) begin
            read_data_d = load_refine(funct3_q, addr_q[1:0], DMEM_RDATA);
          end
          dmem_read_d  = 1'b0;
          dmem_write_d = 1'b0;
          state_d      = DONE;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          // Memory never answered: abandon the access and flag it.
          read_data_d  = '0;
          mem_fault_d  = 1'b1;
          dmem_read_d  = 1'b0;
          dmem_write_d = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: begin
        // One non-stalled cycle lets the pipeline advance past this access.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      is_write_q   <= 1'b0;
      cnt_q        <= '0;
      read_data_q  <= '0;
      dmem_read_q  <= 1'b0;
      dmem_write_q <= 1'b0;
      misaligned_q <= 1'b0;
      mem_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      is_write_q   <= is_write_d;
      cnt_q        <= cnt_d;
      read_data_q  <= read_data_d;
      dmem_read_q  <= dmem_read_d;
      dmem_write_q <= dmem_write_d;
      misaligned_q <= misaligned_d;
      mem_fault_q  <= mem_fault_d;
    end
  end

  // Memory-side outputs are driven only while a strobe is up.
  always_comb begin
    DMEM_ADDR   = '0;
    DMEM_WDATA  = '0;
    DMEM_BYTEEN = 4'h0;
    if (dmem_read_q | dmem_write_q) begin
      DMEM_ADDR = {addr_q[ADDR_W-1:2], 2'b00};
    end
    if (dmem_write_q) begin
      DMEM_WDATA  = store_wdata(funct3_q, wdata_q);
      DMEM_BYTEEN = store_be(funct3_q, addr_q[1:0]);
    end else if (dmem_read_q) begin
      DMEM_BYTEEN = 4'b1111;
    end
  end

  assign READ_DATA  = read_data_q;
  assign DMEM_READ  = dmem_read_q;
  assign DMEM_WRITE = dmem_write_q;
  assign MISALIGNED = misaligned_q;
  assign MEM_FAULT  = mem_fault_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a load-result scoreboard.
// A second instance with a short timeout exercises the abort path.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        busywait, misaligned, mem_fault;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_byteen;
  logic [31:0] dmem_rdata;
  logic        dmem_busywait;

  logic        t_mem_read, t_mem_write;
  logic [2:0]  t_funct3;
  logic [31:0] t_address, t_write_data;
  logic [31:0] t_read_data;
  logic        t_busywait, t_misaligned, t_mem_fault;
  logic        t_dmem_read, t_dmem_write;
  logic [31:0] t_dmem_addr, t_dmem_wdata;
  logic [3:0]  t_dmem_byteen;
  logic [31:0] t_dmem_rdata;
  logic        t_dmem_busywait;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  int          busy_n, strobe_n, acc_n;
  logic [31:0] oa, ow;
  logic [3:0]  ob;

  dmem_access_ctrl dut (
    .CLK(clk), .RESET(rst), .MEM_READ(mem_read), .MEM_WRITE(mem_write),
    .FUNCT3(funct3), .ADDRESS(address), .WRITE_DATA(write_data),
    .READ_DATA(read_data), .BUSYWAIT(busywait), .MISALIGNED(misaligned),
    .MEM_FAULT(mem_fault), .DMEM_READ(dmem_read), .DMEM_WRITE(dmem_write),
    .DMEM_ADDR(dmem_addr), .DMEM_WDATA(dmem_wdata), .DMEM_BYTEEN(dmem_byteen),
    .DMEM_RDATA(dmem_rdata), .DMEM_BUSYWAIT(dmem_busywait)
  );

  dmem_access_ctrl #(.ADDR_W(32), .TIMEOUT(4), .TO_W(8)) dut_to (
    .CLK(clk), .RESET(rst), .MEM_READ(t_mem_read), .MEM_WRITE(t_mem_write),
    .FUNCT3(t_funct3), .ADDRESS(t_address), .WRITE_DATA(t_write_data),
    .READ_DATA(t_read_data), .BUSYWAIT(t_busywait), .MISALIGNED(t_misaligned),
    .MEM_FAULT(t_mem_fault), .DMEM_READ(t_dmem_read), .DMEM_WRITE(t_dmem_write),
    .DMEM_ADDR(t_dmem_addr), .DMEM_WDATA(t_dmem_wdata), .DMEM_BYTEEN(t_dmem_byteen),
    .DMEM_RDATA(t_dmem_rdata), .DMEM_BUSYWAIT(t_dmem_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Issue one request, model the memory wait states, count stall and strobe
  // cycles, and on completion compare READ_DATA against the scoreboard.
  // Returns sampled in the DONE cycle.
  task automatic run_req(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdw,
                         input int waits, input logic [31:0] exp_rd,
                         output int bn, output int sn,
                         output logic [31:0] o_addr, output logic [31:0] o_wdata,
                         output logic [3:0] o_be);
    logic [31:0] e;
    if (rd) exp_q.push_back(exp_rd);
    mem_read      = rd;
    mem_write     = wr;
    funct3        = f;
    address       = a;
    write_data    = wd;
    dmem_rdata    = rdw;
    dmem_busywait = (waits > 0);
    bn = 0; sn = 0; o_addr = '0; o_wdata = '0; o_be = '0;
    #2;
    if (busywait) bn++;
    if (dmem_read | dmem_write) sn++;
    for (int k = 0; k < 64; k++) begin
      tick();
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      dmem_busywait = (k < waits);
      #2;
      if (dmem_read | dmem_write) begin
        if (sn == 0) begin
          o_addr = dmem_addr; o_wdata = dmem_wdata; o_be = dmem_byteen;
        end
        sn++;
      end
      if (!busywait) break;
      bn++;
    end
    chk1({tag, "_stall_released"}, busywait, 1'b0);
    if (rd) begin
      e = exp_q.pop_front();
      chk({tag, "_read_data"}, read_data, e);
    end
    dmem_busywait = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 0; mem_write = 0; funct3 = 0; address = 0; write_data = 0;
    dmem_rdata = 0; dmem_busywait = 0;
    t_mem_read = 0; t_mem_write = 0; t_funct3 = 0; t_address = 0; t_write_data = 0;
    t_dmem_rdata = 0; t_dmem_busywait = 0;
    repeat (3) tick();
    #2;
    chk1("rst_busywait", busywait, 1'b0);
    chk("rst_read_data", read_data, 32'h0);
    chk1("rst_dmem_read", dmem_read, 1'b0);
    chk1("rst_dmem_write", dmem_write, 1'b0);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    chk("rst_dmem_wdata", dmem_wdata, 32'h0);
    chk("rst_byteen", {28'd0, dmem_byteen}, 32'h0);
    chk1("rst_misaligned", misaligned, 1'b0);
    chk1("rst_mem_fault", mem_fault, 1'b0);
    rst = 1'b0;
    tick();

    // LB / LBU from byte 3 with no memory wait.
    run_req("lb", 1, 0, 3'b000, 32'h103, 0, 32'h80FF_1234, 0, 32'hFFFF_FF80,
            busy_n, strobe_n, oa, ow, ob);
    chk("lb_busy_cycles", busy_n, 2);
    chk("lb_strobe_cycles", strobe_n, 1);
    chk("lb_dmem_addr", oa, 32'h100);
    chk("lb_byteen", {28'd0, ob}, 32'hF);
    tick();
    run_req("lbu", 1, 0, 3'b100, 32'h103, 0, 32'h80FF_1234, 0, 32'h0000_0080,
            busy_n, strobe_n, oa, ow, ob);
    chk("lbu_busy_cycles", busy_n, 2);
    tick();

    // SH to the upper halfword; READ_DATA must hold the last load.
    run_req("sh", 0, 1, 3'b001, 32'h22, 32'hAAAA_BEEF, 0, 0, 0,
            busy_n, strobe_n, oa, ow, ob);
    chk("sh_wdata", ow, 32'hBEEF_BEEF);
    chk("sh_byteen", {28'd0, ob}, 32'hC);
    chk("sh_dmem_addr", oa, 32'h20);
    chk("sh_strobe_cycles", strobe_n, 1);
    chk("sh_busy_cycles", busy_n, 2);
    chk("sh_read_data_hold", read_data, 32'h0000_0080);
    tick();

    // SB at byte offset 1.
    run_req("sb", 0, 1, 3'b000, 32'h31, 32'h1234_5678, 0, 0, 0,
            busy_n, strobe_n, oa, ow, ob);
    chk("sb_wdata", ow, 32'h7878_7878);
    chk("sb_byteen", {28'd0, ob}, 32'h2);
    tick();

    // LH / LHU on the upper halfword.
    run_req("lh", 1, 0, 3'b001, 32'h12, 0, 32'h8001_7FFF, 0, 32'hFFFF_8001,
            busy_n, strobe_n, oa, ow, ob);
    tick();
    run_req("lhu", 1, 0, 3'b101, 32'h12, 0, 32'h8001_7FFF, 0, 32'h0000_8001,
            busy_n, strobe_n, oa, ow, ob);
    tick();

    // LW with five memory wait states.
    run_req("lw_wait", 1, 0, 3'b010, 32'h40, 0, 32'h1234_5678, 5, 32'h1234_5678,
            busy_n, strobe_n, oa, ow, ob);
    chk("lw_wait_busy_cycles", busy_n, 7);
    chk("lw_wait_strobe_cycles", strobe_n, 6);
    // A request presented during DONE must not be taken.
    mem_read = 1'b1; funct3 = 3'b010; address = 32'h44;
    #1;
    chk1("done_ignores_req", busywait, 1'b0);
    tick();
    run_req("lw_after_done", 1, 0, 3'b010, 32'h44, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF,
            busy_n, strobe_n, oa, ow, ob);
    chk("lw_after_done_busy_cycles", busy_n, 2);
    tick();

    // Misaligned word load.
    mem_read = 1'b1; funct3 = 3'b010; address = 32'h42;
    #2;
    chk1("mis_busywait_req", busywait, 1'b0);
    tick();
    mem_read = 1'b0;
    #2;
    chk1("mis_pulse", misaligned, 1'b1);
    chk1("mis_no_fault", mem_fault, 1'b0);
    chk1("mis_no_strobe", dmem_read, 1'b0);
    chk1("mis_busywait", busywait, 1'b0);
    tick();
    #2;
    chk1("mis_pulse_end", misaligned, 1'b0);

    // Simultaneous read and write request.
    mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b010; address = 32'h40;
    #2;
    chk1("rw_busywait_req", busywait, 1'b0);
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    #2;
    chk1("rw_fault_pulse", mem_fault, 1'b1);
    chk1("rw_no_mis", misaligned, 1'b0);
    chk1("rw_no_rd_strobe", dmem_read, 1'b0);
    chk1("rw_no_wr_strobe", dmem_write, 1'b0);
    tick();
    #2;
    chk1("rw_fault_end", mem_fault, 1'b0);

    // Reserved FUNCT3 encoding, also misaligned: illegal wins.
    mem_read = 1'b1; funct3 = 3'b011; address = 32'h41;
    tick();
    mem_read = 1'b0;
    #2;
    chk1("f011_fault", mem_fault, 1'b1);
    chk1("f011_no_mis", misaligned, 1'b0);
    chk("fault_read_data_hold", read_data, 32'hDEAD_BEEF);
    tick();

    // Short-timeout instance: a normal load, then an unresponsive memory.
    exp_q.push_back(32'hCAFE_F00D);
    t_mem_read = 1'b1; t_funct3 = 3'b010; t_address = 32'h80;
    t_dmem_rdata = 32'hCAFE_F00D; t_dmem_busywait = 1'b0;
    #2;
    chk1("to_ok_busywait", t_busywait, 1'b1);
    tick();
    t_mem_read = 1'b0;
    #2;
    chk1("to_ok_strobe", t_dmem_read, 1'b1);
    tick();
    #2;
    chk("to_ok_read_data", t_read_data, exp_q.pop_front());
    tick();
    exp_q.push_back(32'h0);
    t_mem_read = 1'b1; t_dmem_busywait = 1'b1;
    #2;
    chk1("to_req_busywait", t_busywait, 1'b1);
    tick();
    t_mem_read = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (!t_busywait) break;
      if (t_dmem_read) acc_n++;
      tick();
    end
    chk("to_access_cycles", acc_n, 4);
    chk1("to_fault_pulse", t_mem_fault, 1'b1);
    chk1("to_strobe_dropped", t_dmem_read, 1'b0);
    chk("to_read_data", t_read_data, exp_q.pop_front());
    t_dmem_busywait = 1'b0;
    tick();
    #2;
    chk1("to_fault_end", t_mem_fault, 1'b0);
    chk1("to_idle_busywait", t_busywait, 1'b0);

    // Reset on the second ACCESS cycle of a stuck store.
    mem_write = 1'b1; funct3 = 3'b010; address = 32'h200;
    write_data = 32'h1122_3344; dmem_busywait = 1'b1;
    #2;
    chk1("rst_mid_req_busy", busywait, 1'b1);
    tick();
    mem_write = 1'b0;
    #2;
    chk1("rst_mid_acc1_strobe", dmem_write, 1'b1);
    tick();
    #2;
    chk1("rst_mid_acc2_strobe", dmem_write, 1'b1);
    chk1("rst_mid_acc2_busy", busywait, 1'b1);
    rst = 1'b1;
    tick();
    #2;
    chk1("rst_mid_strobe_drop", dmem_write, 1'b0);
    chk1("rst_mid_busy_drop", busywait, 1'b0);
    chk1("rst_mid_no_fault", mem_fault, 1'b0);
    chk1("rst_mid_no_mis", misaligned, 1'b0);
    chk("rst_mid_read_data", read_data, 32'h0);
    rst = 1'b0; dmem_busywait = 1'b0;
    tick();
    #2;
    chk1("rst_mid_after_fault", mem_fault, 1'b0);
    chk1("rst_mid_after_strobe", dmem_write, 1'b0);
    tick();
    run_req("sw_after_rst", 0, 1, 3'b010, 32'h204, 32'hA5A5_A5A5, 0, 0, 0,
            busy_n, strobe_n, oa, ow, ob);
    chk("sw_busy_cycles", busy_n, 2);
    chk("sw_wdata", ow, 32'hA5A5_A5A5);
    chk("sw_byteen", {28'd0, ob}, 32'hF);
    chk("sw_dmem_addr", oa, 32'h204);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
